uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Parametrised successor UART receiver. Adds configurable data width, optional second stop bit,
//  3-sample majority voting, false-start rejection and a show-ahead receive FIFO with valid/ready.
//  Sits between the rx pin synchroniser domain and the system control unit; one frame = one FIFO entry.
// PARAMETERS
//  DATA_W      8  data bits per frame (5..9), LSB first on the line
//  PRESCALE_W  6  width of prescale input
//  DEPTH       4  receive FIFO entries (power of 2, >=2)
// PORTS
//  clk          in   1              receiver clock (= prescale x baud)
//  rst          in   1              synchronous, active-high reset
//  prescale     in   PRESCALE_W     clk cycles per bit, legal 4..2^PRESCALE_W-1
//  par_en       in   1              1 = parity bit present
//  par_typ      in   1              0 = even, 1 = odd
//  stop2        in   1              1 = two stop bits expected
//  rx_in        in   1              serial line, idle high, asynchronous
//  rx_data      out  DATA_W         FIFO head data (valid when rx_valid)
//  rx_par_err   out  1              FIFO head parity error flag
//  rx_stop_err  out  1              FIFO head stop/framing error flag
//  rx_valid     out  1              FIFO not empty
//  rx_ready     in   1              consumer pops head when rx_valid & rx_ready
//  fifo_count   out  $clog2(DEPTH+1) entries held
//  overrun      out  1              sticky: frame dropped because FIFO full
//  ovr_clr      in   1              clears overrun (push-drop same cycle wins -> stays 1)
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, rx_valid=0, rx_data=0, flags=0, fifo_count=0, overrun=0, sync flops=1.
//  rst mid-frame aborts frame; nothing pushed.
//  rx_in passes 2-flop synchroniser (+2 clk latency); all decisions on synchronised rxs.
//  prescale/par_en/par_typ/stop2 latched at start detect; frozen for whole frame.
//  Bit timing: edge_cnt 0..P-1 per bit, mid = P>>1; samples at mid-1, mid, mid+1;
//   bit value = majority of 3, decided at edge_cnt == mid+1.
//  FSM:
//   IDLE   : rxs==0 -> START, edge_cnt=1 (the detection cycle counts as cycle 0).
//   START  : at decision, majority 1 -> IDLE (glitch, no push); 0 -> DATA at bit end.
//   DATA   : DATA_W bits shifted LSB first; after last -> PARITY if par_en else STOP.
//   PARITY : par_err = (majority != (^data ^ par_typ)).
//   STOP   : stop_err |= (majority != 1); if stop2, second stop bit also checked.
//            At decision of last stop bit: push {stop_err,par_err,data}, go IDLE immediately
//            (remaining half bit is idle high; next falling edge accepted).
//  Errored frames are pushed with flags set; data pushed as received (not zeroed).
//  FIFO: show-ahead; pop when rx_valid & rx_ready. Push+pop same cycle: count unchanged,
//   allowed even when full. Push when full with no pop: frame dropped, overrun<=1.
//  Pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH.
//  Latency: last stop-bit decision -> rx_valid high next clk (empty FIFO).
// TESTING
//  1 P=8, DATA_W=8, par_en=1, par_typ=1, frame 0x55 parity=1 -> rx_data=0x55, no errors, count=1.
//  2 P=16, par_en=0, stop2=1, 0xA3 with 2nd stop=0 -> rx_data=0xA3, rx_stop_err=1, rx_par_err=0.
//  3 P=8, even parity, 0x33 parity=1 -> rx_par_err=1, stop_err=0; then 0-glitch of 2 clk on idle
//    line -> no push, FSM back to IDLE.
//  4 P=32, single 1-clk glitch inverting each data mid-sample of 0xF0 -> majority gives 0xF0.
//  5 DEPTH=4, rx_ready=0, send 5 frames -> count=4, overrun=1, head=frame 1; ovr_clr -> overrun=0;
//    pop 4 -> frames 1..4 in order, rx_valid=0.
//  6 rst asserted mid-DATA, then clean frame 0x81 -> only 0x81 popped, no spurious entry.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with 3-sample majority voting, false-start rejection, optional parity and
// second stop bit, feeding a show-ahead receive FIFO with a valid/ready pop interface.
module uart_rx_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PRESCALE_W = 6,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PRESCALE_W-1:0]      prescale,
  input  logic                       par_en,
  input  logic                       par_typ,
  input  logic                       stop2,
  input  logic                       rx_in,
  output logic [DATA_W-1:0]          rx_data,
  output logic                       rx_par_err,
  output logic                       rx_stop_err,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic                       overrun,
  input  logic                       ovr_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned BW = $clog2(DATA_W);
  localparam int unsigned EW = DATA_W + 2;
  localparam logic [BW-1:0] LastBit = BW'(DATA_W - 1);
  localparam logic [CW-1:0] Full    = CW'(DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e                  state_q;
  logic                    rx_meta_q, rxs_q;
  logic [PRESCALE_W-1:0]   p_q, edge_q;
  logic                    par_en_q, par_typ_q, stop2_q;
  logic [BW-1:0]           bit_q;
  logic                    stop_idx_q;
  logic                    s0_q, s1_q;
  logic [DATA_W-1:0]       data_q;
  logic                    par_err_q, stop_err_q;

  logic [PRESCALE_W-1:0]   mid, mid_m1, mid_p1;
  logic                    bit_end, decide, maj, last_stop, push;
  logic [EW-1:0]           push_word;

  assign mid       = p_q >> 1;
  assign mid_m1    = mid - PRESCALE_W'(1);
  assign mid_p1    = mid + PRESCALE_W'(1);
  assign bit_end   = (edge_q == p_q - PRESCALE_W'(1));
  assign decide    = (edge_q == mid_p1);
  // Third sample is the live synchronised value at the decision cycle.
  assign maj       = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign last_stop = ~stop2_q | stop_idx_q;
  assign push      = (state_q == StStop) && decide && last_stop;
  assign push_word = {stop_err_q | ~maj, par_err_q, data_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      p_q        <= '0;
      edge_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      stop2_q    <= 1'b0;
      bit_q      <= '0;
      stop_idx_q <= 1'b0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_in;
      rxs_q     <= rx_meta_q;
      if (state_q != StIdle) begin
        edge_q <= bit_end ? '0 : edge_q + PRESCALE_W'(1);
        if (edge_q == mid_m1) s0_q <= rxs_q;
        if (edge_q == mid)    s1_q <= rxs_q;
      end
      case (state_q)
        StIdle: begin
          if (!rxs_q) begin
            state_q    <= StStart;
            edge_q     <= PRESCALE_W'(1);
            p_q        <= prescale;
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            stop2_q    <= stop2;
            bit_q      <= '0;
            stop_idx_q <= 1'b0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
          end
        end
        StStart: begin
          if (decide && maj) state_q <= StIdle;
          else if (bit_end)  state_q <= StData;
        end
        StData: begin
          if (decide) data_q <= {maj, data_q[DATA_W-1:1]};
          if (bit_end) begin
            if (bit_q == LastBit) state_q <= par_en_q ? StParity : StStop;
            else                  bit_q   <= bit_q + BW'(1);
          end
        end
        StParity: begin
          if (decide)  par_err_q <= (maj != (^data_q ^ par_typ_q));
          if (bit_end) state_q   <= StStop;
        end
        StStop: begin
          if (decide) begin
            stop_err_q <= stop_err_q | ~maj;
            if (last_stop) state_q <= StIdle;
          end
          if (bit_end) stop_idx_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic          full, pop, wr_en, drop;

  assign full  = (count_q == Full);
  assign pop   = rx_valid & rx_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + AW'(1);
      if (pop)   rd_q <= rd_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (drop)         overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

  assign rx_valid   = (count_q != '0);
  assign fifo_count = count_q;
  assign {rx_stop_err, rx_par_err, rx_data} = rx_valid ? mem_q[rd_q] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised scoreboard bench for uart_rx_fifo: frames are generated bit-by-bit on the line,
// expected entries are queued by a frame-level model and checked as the DUT presents them.
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;

  logic       clk, rst;
  logic [5:0] prescale;
  logic       par_en, par_typ, stop2, rx_in;
  logic [7:0] rx_data;
  logic       rx_par_err, rx_stop_err, rx_valid, rx_ready;
  logic [2:0] fifo_count;
  logic       overrun, ovr_clr;

  uart_rx_fifo #(.DATA_W(8), .PRESCALE_W(6), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .stop2      (stop2),
    .rx_in      (rx_in),
    .rx_data    (rx_data),
    .rx_par_err (rx_par_err),
    .rx_stop_err(rx_stop_err),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .fifo_count (fifo_count),
    .overrun    (overrun),
    .ovr_clr    (ovr_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_vec  = 0;
  int         n_fail = 0;
  int         ready_mode;  // 0: hold off, 1: random, 2: always ready
  int         hold_cnt;
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(posedge clk);
    #1;
    rx_ready = (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : (ready_mode == 2);
  end

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {22'd0, rx_stop_err, rx_par_err, rx_data}, 32'hFFFF_FFFF);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("pop", {22'd0, rx_stop_err, rx_par_err, rx_data}, {22'd0, e});
      end
    end
  end

  task automatic drive_cell(input logic v, input int p, input int gpos);
    for (int c = 0; c < p; c++) begin
      @(posedge clk);
      #1;
      rx_in = (c == gpos) ? ~v : v;
    end
  endtask

  // gmode: 0 clean, 1 glitch at mid of every data bit, 2 glitch at random sample slot
  task automatic send_frame(input logic [7:0] d, input int p, input bit pe, input bit pt,
                            input bit s2, input bit par_bit, input bit stop_a, input bit stop_b,
                            input int gmode);
    int         mid, g;
    logic [9:0] e;
    prescale = 6'(p);
    par_en   = pe;
    par_typ  = pt;
    stop2    = s2;
    mid      = p / 2;
    e[7:0]   = d;
    e[8]     = pe && ((($countones(d) + int'(par_bit)) % 2) != int'(pt));
    e[9]     = !stop_a || (s2 && !stop_b);
    if (ready_mode == 0) begin
      if (hold_cnt < DEPTH) begin
        exp_q.push_back(e);
        hold_cnt++;
      end
    end else begin
      exp_q.push_back(e);
    end
    drive_cell(1'b0, p, -1);
    for (int i = 0; i < 8; i++) begin
      g = (gmode == 0) ? -1 : (gmode == 1) ? mid : mid - 1 + int'($urandom_range(0, 2));
      drive_cell(d[i], p, g);
    end
    if (pe) drive_cell(par_bit, p, -1);
    drive_cell(stop_a, p, -1);
    if (s2) drive_cell(stop_b, p, -1);
    drive_cell(1'b1, p + 2 + int'($urandom_range(0, p)), -1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || rx_valid); i++) @(posedge clk);
    #1;
    check("drain_queue", exp_q.size(), 0);
    check("drain_valid", {31'd0, rx_valid}, 0);
  endtask

  initial begin
    rst = 1'b1; rx_in = 1'b1; ovr_clr = 1'b0; prescale = 6'd8;
    par_en = 1'b0; par_typ = 1'b0; stop2 = 1'b0; ready_mode = 0; hold_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'd0, rx_valid}, 0);
    check("rst_data", {24'd0, rx_data}, 0);
    check("rst_flags", {30'd0, rx_stop_err, rx_par_err}, 0);
    check("rst_count", {29'd0, fifo_count}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    rst = 1'b0;
    drive_cell(1'b1, 10, -1);

    // Odd parity, clean frame held in the FIFO
    send_frame(8'h55, 8, 1, 1, 0, 1, 1, 1, 0);
    check("t1_count", {29'd0, fifo_count}, 1);
    check("t1_head", {22'd0, rx_stop_err, rx_par_err, rx_data}, {22'd0, 10'h055});
    hold_cnt = 0;
    ready_mode = 1;
    wait_drain();

    // Second stop bit low
    send_frame(8'hA3, 16, 0, 0, 1, 0, 1, 0, 0);
    // Even parity with wrong parity bit
    send_frame(8'h33, 8, 1, 0, 0, 1, 1, 1, 0);
    wait_drain();

    // Short low glitch on an idle line must be rejected
    prescale = 6'd8;
    drive_cell(1'b0, 2, -1);
    drive_cell(1'b1, 30, -1);
    check("glitch_count", {29'd0, fifo_count}, 0);
    send_frame(8'h5A, 8, 0, 0, 0, 0, 1, 1, 0);

    // Glitches on every data mid-sample, outvoted by the neighbours
    send_frame(8'hF0, 32, 0, 0, 0, 0, 1, 1, 1);
    wait_drain();

    // Overrun: five frames into a four-entry FIFO with no consumer
    ready_mode = 0;
    hold_cnt = 0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 6, 0, 0, 0, 0, 1, 1, 0);
    check("ovr_count", {29'd0, fifo_count}, DEPTH);
    check("ovr_flag", {31'd0, overrun}, 1);
    check("ovr_head", {22'd0, rx_stop_err, rx_par_err, rx_data}, {22'd0, exp_q[0]});
    ovr_clr = 1'b1;
    @(posedge clk);
    #1;
    ovr_clr = 1'b0;
    check("ovr_clr", {31'd0, overrun}, 0);
    ready_mode = 1;
    wait_drain();

    // Reset in the middle of the data bits aborts the frame
    prescale = 6'd8;
    drive_cell(1'b0, 8, -1);
    drive_cell(1'b1, 8, -1);
    drive_cell(1'b0, 8, -1);
    drive_cell(1'b1, 3, -1);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_count", {29'd0, fifo_count}, 0);
    check("midrst_valid", {31'd0, rx_valid}, 0);
    drive_cell(1'b1, 20, -1);
    send_frame(8'h81, 8, 0, 0, 0, 0, 1, 1, 0);
    wait_drain();

    // Randomised frames with random consumer back-pressure
    for (int n = 0; n < 30; n++) begin
      send_frame(8'($urandom), int'($urandom_range(4, 20)), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), $urandom_range(0, 5) != 0,
                 $urandom_range(0, 5) != 0, $urandom_range(0, 1) * 2);
    end
    wait_drain();
    check("final_overrun", {31'd0, overrun}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
